// File: rtl/audio_clk_gen_pkg.sv
// Shared types and default configuration for the I2S clock generator.
package audio_clk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } clk_state_t;

  localparam int ACC_W_DEF       = 18;
  localparam int SCK_BIT_DEF     = 13;
  localparam int BCK_BIT_DEF     = 17;
  localparam int BITS_PER_CH_DEF = 16;
  localparam int INC_DEFAULT_DEF = 63;

endpackage

// File: rtl/audio_clk_gen_lrck_gen.sv
// Word-select generator: counts bck falling edges into channel halves.
// I2S_DELAY_EN moves the lrck toggle one bit ahead of the channel wrap (Philips I2S).
module lrck_gen #(
  parameter int BITS_PER_CH = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic fall,
  input  logic clear,
  input  logic start,
  output logic lrck,
  output logic frame_start,
  output logic frame_end
);

  localparam int CW = $clog2(BITS_PER_CH);
  localparam logic [CW-1:0] LAST = CW'(BITS_PER_CH - 1);
`ifdef I2S_DELAY_EN
  localparam logic [CW-1:0] TOGGLE = CW'(BITS_PER_CH - 2);
`endif

  logic [CW-1:0] bit_cnt;
  logic          chan;
  logic          wrap;

  // chan tracks the true channel half; lrck may lead it by one bit
  assign wrap      = fall && (bit_cnt == LAST);
  assign frame_end = wrap && chan;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      bit_cnt     <= '0;
      chan        <= 1'b0;
      lrck        <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= start | frame_end;
      if (start) begin
        bit_cnt <= '0;
        chan    <= 1'b0;
        lrck    <= 1'b0;
      end else if (fall) begin
        bit_cnt <= wrap ? '0 : bit_cnt + 1'b1;
        if (wrap) chan <= ~chan;
`ifdef I2S_DELAY_EN
        if (bit_cnt == TOGGLE) lrck <= ~lrck;
`else
        if (wrap) lrck <= ~lrck;
`endif
      end
    end
  end

endmodule

// File: rtl/audio_clk_gen.sv
// NCO-based I2S clock generator: sck/bck from a phase accumulator, lrck and strobes.
// Optional macro I2S_DELAY_EN selects Philips I2S lrck timing (see lrck_gen).
module audio_clk_gen
  import audio_clk_pkg::*;
#(
  parameter int ACC_W       = ACC_W_DEF,
  parameter int SCK_BIT     = SCK_BIT_DEF,
  parameter int BCK_BIT     = BCK_BIT_DEF,
  parameter int BITS_PER_CH = BITS_PER_CH_DEF,
  parameter int INC_DEFAULT = INC_DEFAULT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [ACC_W-1:0] inc,
  input  logic             inc_valid,
  output logic             inc_ready,
  output logic             sck,
  output logic             bck,
  output logic             lrck,
  output logic             bck_rise,
  output logic             bck_fall,
  output logic             frame_start,
  output logic             running
);

  clk_state_t       state, state_next;
  logic [ACC_W-1:0] acc, acc_next;
  logic [ACC_W-1:0] active_inc, pending_inc;
  logic             pending_valid;
  logic             rise_next, fall_next;
  logic             frame_end, clear, start, xfer;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (en) state_next = RUN;
      RUN:     if (!en) state_next = DRAIN;
      DRAIN:   if (en) state_next = RUN;
               else if (frame_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Strobes are derived from the accumulator update so they line up with the new bck level
  assign acc_next  = (state == IDLE) ? '0 : acc + active_inc;
  assign rise_next = ~acc[BCK_BIT] & acc_next[BCK_BIT];
  assign fall_next = acc[BCK_BIT] & ~acc_next[BCK_BIT];
  assign clear     = (state_next == IDLE);
  assign start     = (state == IDLE) && en;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc      <= '0;
      bck_rise <= 1'b0;
      bck_fall <= 1'b0;
    end else begin
      acc      <= clear ? '0 : acc_next;
      bck_rise <= rise_next & ~clear;
      bck_fall <= fall_next & ~clear;
    end
  end

  // inc transfers when inc_valid & inc_ready; while running it waits in pending
  // and is applied at frame_start, so the rate only changes on frame boundaries.
  assign inc_ready = ~pending_valid;
  assign xfer      = inc_valid & inc_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      active_inc    <= ACC_W'(INC_DEFAULT);
      pending_inc   <= '0;
      pending_valid <= 1'b0;
    end else if (state == IDLE) begin
      if (xfer) active_inc <= inc;
    end else begin
      if (frame_start && pending_valid) begin
        active_inc    <= pending_inc;
        pending_valid <= 1'b0;
      end
      if (xfer) begin
        pending_inc   <= inc;
        pending_valid <= 1'b1;
      end
    end
  end

  lrck_gen #(
    .BITS_PER_CH (BITS_PER_CH)
  ) u_lrck_gen (
    .clk         (clk),
    .reset       (reset),
    .fall        (fall_next),
    .clear       (clear),
    .start       (start),
    .lrck        (lrck),
    .frame_start (frame_start),
    .frame_end   (frame_end)
  );

  assign sck     = acc[SCK_BIT];
  assign bck     = acc[BCK_BIT];
  assign running = (state != IDLE);

endmodule

// File: tb/tb_audio_clk_gen.sv
// Directed bench for audio_clk_gen with ACC_W=8, SCK_BIT=2, BCK_BIT=4, BITS_PER_CH=4, INC_DEFAULT=1.
module tb_audio_clk_gen;

  logic       clk;
  logic       reset;
  logic       en;
  logic [7:0] inc;
  logic       inc_valid;
  logic       inc_ready;
  logic       sck, bck, lrck, bck_rise, bck_fall, frame_start, running;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int both_cnt = 0;
  int sck_q[$], lrck_q[$], rise_q[$], fall_q[$], fs_q[$];
  logic sck_p = 1'b0;
  logic lrck_p = 1'b0;

  audio_clk_gen #(
    .ACC_W       (8),
    .SCK_BIT     (2),
    .BCK_BIT     (4),
    .BITS_PER_CH (4),
    .INC_DEFAULT (1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .inc         (inc),
    .inc_valid   (inc_valid),
    .inc_ready   (inc_ready),
    .sck         (sck),
    .bck         (bck),
    .lrck        (lrck),
    .bck_rise    (bck_rise),
    .bck_fall    (bck_fall),
    .frame_start (frame_start),
    .running     (running)
  );

  // clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // event monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (sck !== sck_p) sck_q.push_back(cyc);
    if (lrck !== lrck_p) lrck_q.push_back(cyc);
    if (bck_rise) rise_q.push_back(cyc);
    if (bck_fall) fall_q.push_back(cyc);
    if (frame_start) fs_q.push_back(cyc);
    if (bck_rise && bck_fall) both_cnt++;
    sck_p  = sck;
    lrck_p = lrck;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_q;
    sck_q.delete();
    lrck_q.delete();
    rise_q.delete();
    fall_q.delete();
    fs_q.delete();
  endtask

  function automatic logic [7:0] outs();
    return {sck, bck, lrck, bck_rise, bck_fall, frame_start, running, inc_ready};
  endfunction

  int   s, f, s2, s3, n, low_cnt;
  logic found, lrck_last;

  initial begin
    reset = 1'b1; en = 1'b0; inc = '0; inc_valid = 1'b0;
    repeat (3) tick;
    check_eq("reset_outs", outs(), 8'b0000_0001);
    reset = 1'b0;
    tick;
    check_eq("idle_outs", outs(), 8'b0000_0001);

    // default rate from reset
    clear_q();
    en = 1'b1;
    tick;
    s = cyc;
    check_eq("run_first_fs", {frame_start, running, lrck}, 3'b110);
    repeat (400) tick;
    check_eq("fs0_at", fs_q[0] - s, 0);
    check_eq("fs1_at", fs_q[1] - s, 256);
    check_eq("fs_count", fs_q.size(), 2);
    check_eq("rise0_at", rise_q[0] - s, 16);
    check_eq("rise_period", rise_q[1] - rise_q[0], 32);
    check_eq("rise_count", rise_q.size(), 12);
    check_eq("fall0_at", fall_q[0] - s, 32);
    check_eq("fall_count", fall_q.size(), 12);
    check_eq("sck0_at", sck_q[0] - s, 4);
    check_eq("sck_period", sck_q[2] - sck_q[0], 8);
`ifdef I2S_DELAY_EN
    check_eq("lrck0_at", lrck_q[0] - s, 96);
`else
    check_eq("lrck0_at", lrck_q[0] - s, 128);
`endif
    check_eq("lrck_period", lrck_q[2] - lrck_q[0], 256);
    check_eq("strobe_overlap", both_cnt, 0);

    // retune to inc=2 mid-frame
    check_eq("ready_before_offer", inc_ready, 1);
    clear_q();
    inc = 8'd2; inc_valid = 1'b1;
    tick;
    inc_valid = 1'b0;
    check_eq("ready_drop", inc_ready, 0);
    n = 0;
    while (frame_start !== 1'b1 && n < 200) begin
      tick;
      n++;
    end
    found = frame_start;
    check_eq("retune_fs_found", found, 1);
    f = cyc;
    check_eq("retune_fs_at", f - s, 512);
    check_eq("ready_at_fs", inc_ready, 0);
    check_eq("old_bck_period", rise_q[1] - rise_q[0], 32);
    check_eq("old_sck_half", sck_q[1] - sck_q[0], 4);
    clear_q();
    tick;
    check_eq("ready_back", inc_ready, 1);
    repeat (140) tick;
    check_eq("new_fall0_at", fall_q[0] - f, 0);
    check_eq("new_rise0_at", rise_q[0] - f, 9);
    check_eq("new_fall1_at", fall_q[1] - f, 17);
    check_eq("new_bck_period", rise_q[1] - rise_q[0], 16);
    check_eq("new_sck1_at", sck_q[1] - f, 3);
    check_eq("new_sck_period", sck_q[3] - sck_q[1], 4);
    check_eq("new_fs1_at", fs_q[1] - f, 129);

    // drain from mid-left channel
    en = 1'b0;
    tick;
    check_eq("drain_running", running, 1);
    n = 0;
    lrck_last = 1'b0;
    while (running === 1'b1 && n < 300) begin
      lrck_last = lrck;
      tick;
      n++;
    end
    check_eq("drain_stopped", running, 0);
    check_eq("drain_end_at", cyc - f, 257);
`ifdef I2S_DELAY_EN
    check_eq("drain_last_lrck", lrck_last, 0);
`else
    check_eq("drain_last_lrck", lrck_last, 1);
`endif
    check_eq("drain_idle_outs", outs(), 8'b0000_0001);
    repeat (5) tick;
    check_eq("idle_frozen", outs(), 8'b0000_0001);

    // en re-asserted during DRAIN, inc=2 still active
    clear_q();
    en = 1'b1;
    tick;
    s2 = cyc;
    low_cnt = 0;
    check_eq("rerun_fs", frame_start, 1);
    for (int i = 0; i < 140; i++) begin
      if (i == 20) en = 1'b0;
      if (i == 40) en = 1'b1;
      if (running !== 1'b1) low_cnt++;
      tick;
    end
    check_eq("redrain_no_gap", low_cnt, 0);
    check_eq("redrain_running", running, 1);
    check_eq("redrain_fall0", fall_q[0] - s2, 16);
    check_eq("redrain_fall_span", fall_q[4] - fall_q[0], 64);
    check_eq("redrain_fall_count", fall_q.size(), 8);
    check_eq("redrain_fs1", fs_q[1] - s2, 128);
`ifdef I2S_DELAY_EN
    check_eq("redrain_lrck0", lrck_q[0] - s2, 48);
    check_eq("redrain_lrck1", lrck_q[1] - s2, 112);
`else
    check_eq("redrain_lrck0", lrck_q[0] - s2, 64);
    check_eq("redrain_lrck1", lrck_q[1] - s2, 128);
`endif

    // reset with a pending increment
    inc = 8'd4; inc_valid = 1'b1;
    tick;
    inc_valid = 1'b0;
    check_eq("pending_ready", inc_ready, 0);
    reset = 1'b1; en = 1'b0;
    tick;
    check_eq("midrun_reset_outs", outs(), 8'b0000_0001);
    reset = 1'b0;
    tick;
    clear_q();
    en = 1'b1;
    tick;
    s3 = cyc;
    repeat (40) tick;
    check_eq("post_reset_fs", fs_q[0] - s3, 0);
    check_eq("post_reset_rise", rise_q[0] - s3, 16);
    check_eq("post_reset_sck0", sck_q[0] - s3, 4);
    check_eq("post_reset_sck_half", sck_q[1] - sck_q[0], 4);
    check_eq("post_reset_overlap", both_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
